snake_body_datapath: RTL

//  Datapath responder to the snake movement controller. It holds the head register and the segment

---
 rtl/snake_pkg.sv | 41 ++++
 rtl/snake_body_datapath_if.sv | 42 ++++
 rtl/snake_seg_ram.sv | 23 ++
 rtl/snake_body_datapath.sv | 107 ++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake body datapath.
// Contents: screen/store geometry, dir encoding, segment payload struct,
// default-segment helper.
package snake_pkg;

  localparam int unsigned MAX_LEN  = 64;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned START_X  = 80;
  localparam int unsigned START_Y  = 60;
  localparam int unsigned BLK      = 2;
  localparam int unsigned SEG_W    = X_W + Y_W;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  // One segment = top-left pixel of a 2x2 block.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } seg_t;

  // Default body laid out leftward from the start position, wrapping on x.
  function automatic seg_t def_seg(input logic [ADDR_W-1:0] a);
    int v;
    seg_t s;
    v = int'(START_X) - int'(BLK) * int'({26'd0, a});
    if (v < 0) v = v + int'(SCREEN_W);
    s.x = X_W'(v);
    s.y = Y_W'(START_Y);
    return s;
  endfunction

endpackage

// File: rtl/snake_body_datapath_if.sv
// Controller <-> datapath bus: movement/shift strobes in, registered pixel writes out.
// master: controller side (drives strobes, dir, colour_in; sees pixel outputs)
// slave : datapath side
interface snake_body_datapath_if;
  import snake_pkg::*;

  logic [1:0]     dir;
  logic           ld_head;
  logic           ld_def;
  logic           update_head;
  logic           ld_head_prev;
  logic           ld_q_curr;
  logic           ld_prev_q;
  logic           ld_curr_prev;
  logic           inc_address;
  logic           rst_address;
  logic           drawQ;
  logic           drawCurr;
  logic           rowNum;
  logic           colNum;
  logic [2:0]     colour_in;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     colour;
  logic           plot;
  logic           wall_hit;

  modport master (
    output dir, ld_head, ld_def, update_head, ld_head_prev, ld_q_curr, ld_prev_q,
           ld_curr_prev, inc_address, rst_address, drawQ, drawCurr, rowNum, colNum,
           colour_in,
    input  x, y, colour, plot, wall_hit
  );

  modport slave (
    input  dir, ld_head, ld_def, update_head, ld_head_prev, ld_q_curr, ld_prev_q,
           ld_curr_prev, inc_address, rst_address, drawQ, drawCurr, rowNum, colNum,
           colour_in,
    output x, y, colour, plot, wall_hit
  );

endinterface

// File: rtl/snake_seg_ram.sv
// Segment coordinate store: DEPTH x DW register file, async read, sync write, no reset.
// Ports: clk; we (write enable); addr (shared read/write address); wdata; q (async read data).
module snake_seg_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign q = mem[addr];

endmodule

// File: rtl/snake_body_datapath.sv
// Snake body datapath: head register, segment store and shift registers driven by
// controller strobes; emits registered 2x2-block pixel writes.
// Ports: clk; rst (async, active-low); bus (snake_body_datapath_if.slave).
// Build option: define SNAKE_WALL_DETECT_EN to stop the head at screen edges and
// raise a sticky wall_hit instead of wrapping.
module snake_body_datapath
  import snake_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  snake_body_datapath_if.slave  bus
);

`ifdef SNAKE_WALL_DETECT_EN
  localparam bit WALL_EN = 1'b1;
`else
  localparam bit WALL_EN = 1'b0;
`endif

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - BLK);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - BLK);
  localparam seg_t           START = '{x: X_W'(START_X), y: Y_W'(START_Y)};

  seg_t              head, prev, curr;
  logic [ADDR_W-1:0] addr;
  seg_t              q;
  seg_t              wdata_c;
  logic              we_c;
  seg_t              head_nxt_c;
  logic              edge_c;
  seg_t              base_c;
  logic              wall_q;

  // ld_def has priority over ld_prev_q; no writes while reset is held.
  assign we_c    = rst & (bus.ld_def | bus.ld_prev_q);
  assign wdata_c = bus.ld_def ? def_seg(addr) : prev;

  snake_seg_ram #(.DEPTH(MAX_LEN), .AW(ADDR_W), .DW(SEG_W)) u_ram (
    .clk   (clk),
    .we    (we_c),
    .addr  (addr),
    .wdata (wdata_c),
    .q     (q)
  );

  // One-block head step with screen wrap; edge_c flags a wrap.
  always_comb begin
    head_nxt_c = head;
    edge_c     = 1'b0;
    case (bus.dir)
      DIR_RIGHT: if (head.x == X_MAX) begin head_nxt_c.x = '0; edge_c = 1'b1; end
                 else head_nxt_c.x = head.x + X_W'(BLK);
      DIR_LEFT:  if (head.x == '0) begin head_nxt_c.x = X_MAX; edge_c = 1'b1; end
                 else head_nxt_c.x = head.x - X_W'(BLK);
      DIR_UP:    if (head.y == '0) begin head_nxt_c.y = Y_MAX; edge_c = 1'b1; end
                 else head_nxt_c.y = head.y - Y_W'(BLK);
      default:   if (head.y == Y_MAX) begin head_nxt_c.y = '0; edge_c = 1'b1; end
                 else head_nxt_c.y = head.y + Y_W'(BLK);
    endcase
  end

  assign base_c = bus.drawQ ? q : curr;

  // Head, shift registers and address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head   <= START;
      prev   <= '0;
      curr   <= '0;
      addr   <= '0;
      wall_q <= 1'b0;
    end else begin
      if (bus.ld_head) head <= START;
      else if (bus.update_head && !(WALL_EN && edge_c)) head <= head_nxt_c;

      if (bus.update_head && WALL_EN && edge_c) wall_q <= 1'b1;

      if (bus.ld_head_prev)      prev <= head;
      else if (bus.ld_curr_prev) prev <= curr;

      if (bus.ld_q_curr) curr <= q;

      if (bus.rst_address)      addr <= '0;
      else if (bus.inc_address) addr <= addr + ADDR_W'(1);
    end
  end

  // Pixel write register; coordinates and colour hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= '0;
      bus.plot   <= 1'b0;
    end else begin
      bus.plot <= bus.drawQ | bus.drawCurr;
      if (bus.drawQ || bus.drawCurr) begin
        bus.x      <= base_c.x + X_W'(bus.colNum);
        bus.y      <= base_c.y + Y_W'(bus.rowNum);
        bus.colour <= bus.drawQ ? bus.colour_in : COLOUR_BLACK;
      end
    end
  end

  assign bus.wall_hit = wall_q;

endmodule
